// File: rtl/pattern_fill_engine.sv
// pattern_fill_engine
//
// Writes a full framebuffer pattern into video RAM, one pixel per accepted
// write. The scan is column-major: the row index advances first, and the
// column index advances when the row wraps.
//
// Parameters
//   COLS, ROWS  framebuffer size in pixels (powers of two, >= 2)
//   STRIPES     stripes per axis (power of two, 2 .. min(COLS, ROWS))
//   COLOR_W     pixel colour width
//
// Ports
//   Clock         system clock
//   Reset         synchronous, active-low reset
//   iStart        start request, sampled only in IDLE
//   iAbort        stop the fill and return to IDLE without oDone
//   iMode         0 vertical stripes, 1 horizontal stripes, 2 checker, 3 solid
//   iColorA/B     first / second colour, latched at start
//   iWriteReady   RAM port accepts the current write
//   oWriteEnable  write request valid (high throughout RUN)
//   oCol, oRow    current pixel coordinates
//   oColor        current pixel colour
//   oBusy         high while in RUN
//   oDone         one-cycle pulse after the last pixel is accepted
//   oDbgState     current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a write transfers on every rising edge where oWriteEnable and
// iWriteReady are both high. While oWriteEnable is high and iWriteReady is
// low, oCol/oRow/oColor/oWriteEnable hold stable until the transfer happens.
// Every output is driven from registers only, so iWriteReady never reaches
// an output combinationally.
module pattern_fill_engine #(
  parameter int COLS    = 256,
  parameter int ROWS    = 256,
  parameter int STRIPES = 4,
  parameter int COLOR_W = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     iStart,
  input  logic                     iAbort,
  input  logic [1:0]               iMode,
  input  logic [COLOR_W-1:0]       iColorA,
  input  logic [COLOR_W-1:0]       iColorB,
  input  logic                     iWriteReady,
  output logic                     oWriteEnable,
  output logic [$clog2(COLS)-1:0]  oCol,
  output logic [$clog2(ROWS)-1:0]  oRow,
  output logic [COLOR_W-1:0]       oColor,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [1:0]               oDbgState
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  // Bit of the counter that selects odd/even stripe: stripe width is
  // COLS/STRIPES pixels, so the stripe index LSB sits at that log2 position.
  localparam int CS_BIT = $clog2(COLS / STRIPES);
  localparam int RS_BIT = $clog2(ROWS / STRIPES);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [1:0]          mode_q, mode_d;
  logic [COLOR_W-1:0]  color_a_q, color_a_d;
  logic [COLOR_W-1:0]  color_b_q, color_b_d;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= '0;
      color_a_q <= '0;
      color_b_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      color_a_q <= color_a_d;
      color_b_q <= color_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    mode_d    = mode_q;
    color_a_d = color_a_q;
    color_b_d = color_b_q;

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          mode_d    = iMode;
          color_a_d = iColorA;
          color_b_d = iColorB;
          col_d     = '0;
          row_d     = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        // Abort wins over acceptance; the pixel on the bus this cycle is
        // still written by the RAM, but the scan is discarded.
        if (iAbort) begin
          col_d   = '0;
          row_d   = '0;
          state_d = S_IDLE;
        end else if (iWriteReady) begin
          if (row_q == ROW_LAST) begin
            // Both counters wrap to zero after the final pixel, so the
            // engine parks at (0,0) with no extra clearing needed.
            row_d = '0;
            col_d = col_q + 1'b1;
            if (col_q == COL_LAST) begin
              state_d = S_DONE;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        col_d   = '0;
        row_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        col_d   = '0;
        row_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  logic col_stripe;
  logic row_stripe;

  assign col_stripe = col_q[CS_BIT];
  assign row_stripe = row_q[RS_BIT];

  always_comb begin
    oColor = color_a_q;
    unique case (mode_q)
      2'd0:    oColor = col_stripe ? color_b_q : color_a_q;
      2'd1:    oColor = row_stripe ? color_b_q : color_a_q;
      2'd2:    oColor = (col_stripe ^ row_stripe) ? color_b_q : color_a_q;
      default: oColor = color_a_q;
    endcase
  end

  assign oWriteEnable = (state_q == S_RUN);
  assign oBusy        = (state_q == S_RUN);
  assign oDone        = (state_q == S_DONE);
  assign oCol         = col_q;
  assign oRow         = row_q;
  assign oDbgState    = state_q;

endmodule

// File: tb/tb_pattern_fill_engine.sv
// Testbench for pattern_fill_engine with an 8x8 framebuffer and 4 stripes.
module tb_pattern_fill_engine;

  localparam int COLS    = 8;
  localparam int ROWS    = 8;
  localparam int STRIPES = 4;
  localparam int COLOR_W = 3;
  localparam int NPIX    = COLS * ROWS;

  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] YELLOW = 3'b110;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- DUT
  logic         start;
  logic         abort_req;
  logic [1:0]   mode;
  logic [2:0]   color_a;
  logic [2:0]   color_b;
  logic         wr_ready;
  logic         wr_en;
  logic [2:0]   col;
  logic [2:0]   row;
  logic [2:0]   color;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  pattern_fill_engine #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .STRIPES (STRIPES),
    .COLOR_W (COLOR_W)
  ) dut (
    .Clock        (clk),
    .Reset        (rst_n),
    .iStart       (start),
    .iAbort       (abort_req),
    .iMode        (mode),
    .iColorA      (color_a),
    .iColorB      (color_b),
    .iWriteReady  (wr_ready),
    .oWriteEnable (wr_en),
    .oCol         (col),
    .oRow         (row),
    .oColor       (color),
    .oBusy        (busy),
    .oDone        (done),
    .oDbgState    (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int vecs;
  int errs;
  int acc_cnt;
  int done_total;

  logic [8:0] exp_q[$];        // {col, row, colour} per expected write
  logic [8:0] last_obs;
  logic [2:0] pix_seen[COLS][ROWS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] model_color(input int m, input logic [2:0] a,
                                             input logic [2:0] b, input int c, input int r);
    int cs;
    int rs;
    cs = (c / (COLS / STRIPES)) % 2;
    rs = (r / (ROWS / STRIPES)) % 2;
    case (m)
      0:       return (cs == 0) ? a : b;
      1:       return (rs == 0) ? a : b;
      2:       return ((cs ^ rs) == 0) ? a : b;
      default: return a;
    endcase
  endfunction

  task automatic push_frame(input int m, input logic [2:0] a, input logic [2:0] b, input int n);
    for (int idx = 0; idx < n; idx++) begin
      int c;
      int r;
      c = idx / ROWS;
      r = idx % ROWS;
      exp_q.push_back({3'(c), 3'(r), model_color(m, a, b, c, r)});
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_total++;
      chk("done_busy_exclusive", {31'd0, busy}, 32'd0);
    end
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_unexpected", {31'd0, wr_en}, 32'd0);
      end else if (wr_ready === 1'b1) begin
        chk("pixel", {23'd0, col, row, color}, {23'd0, exp_q[0]});
        void'(exp_q.pop_front());
        last_obs = {col, row, color};
        pix_seen[col][row] = color;
        acc_cnt++;
      end else begin
        chk("stall_hold", {23'd0, col, row, color}, {23'd0, exp_q[0]});
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Starts a frame in the cycle after the call; the start cycle is cycle 1.
  task automatic run_frame(input int m, input logic [2:0] a, input logic [2:0] b,
                           input bit bp, input bit ign);
    int cyc;
    int done_cyc;
    int acc_base;
    @(posedge clk); #1;
    chk("idle_before_start_done", {31'd0, done}, 32'd0);
    chk("idle_before_start_busy", {31'd0, busy}, 32'd0);
    push_frame(m, a, b, NPIX);
    acc_base = acc_cnt;
    done_cyc = 0;
    mode     = 2'(m);
    color_a  = a;
    color_b  = b;
    start    = 1'b1;
    cyc      = 1;
    for (int k = 0; k < 400 && done_cyc == 0; k++) begin
      @(posedge clk); #1;
      cyc++;
      start   = 1'b0;
      color_a = a;
      mode    = 2'(m);
      if (bp) begin
        case (cyc % 4)
          0:       wr_ready = 1'b1;
          1:       wr_ready = 1'b0;
          2:       wr_ready = 1'b0;
          default: wr_ready = 1'b1;
        endcase
      end
      if (ign && cyc == 10) begin
        start   = 1'b1;
        color_a = ~a;
        mode    = 2'(m) ^ 2'd1;
      end
      if (done === 1'b1) done_cyc = cyc;
    end
    wr_ready = 1'b1;
    chk("done_seen", {31'd0, done_cyc != 0}, 32'd1);
    if (!bp) chk("done_cycle", done_cyc, 66);
    chk("accept_count", acc_cnt - acc_base, NPIX);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int found;
    int done_before;

    vecs       = 0;
    errs       = 0;
    acc_cnt    = 0;
    done_total = 0;
    last_obs   = '0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort_req  = 1'b0;
    mode       = 2'd0;
    color_a    = 3'd0;
    color_b    = 3'd0;
    wr_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_we", {31'd0, wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pixel", {23'd0, col, row, color}, 32'd0);

    // Reset held low for two cycles in the middle of a stalled fill.
    wr_ready = 1'b0;
    exp_q.push_back({3'd0, 3'd0, WHITE});
    mode     = 2'd0;
    color_a  = WHITE;
    color_b  = YELLOW;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_we", {31'd0, wr_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_pixel", {23'd0, col, row, color}, 32'd0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    exp_q.delete();
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_idle_we", {31'd0, wr_en}, 32'd0);

    // Vertical stripes, full frame with exact done timing.
    run_frame(0, WHITE, YELLOW, 1'b0, 1'b0);

    // Checkerboard with spot checks of specific pixels.
    run_frame(2, WHITE, YELLOW, 1'b0, 1'b0);
    chk("chk_0_0", {29'd0, pix_seen[0][0]}, {29'd0, WHITE});
    chk("chk_0_2", {29'd0, pix_seen[0][2]}, {29'd0, YELLOW});
    chk("chk_2_0", {29'd0, pix_seen[2][0]}, {29'd0, YELLOW});
    chk("chk_2_2", {29'd0, pix_seen[2][2]}, {29'd0, WHITE});
    chk("chk_7_7", {29'd0, pix_seen[7][7]}, {29'd0, WHITE});

    // Horizontal stripes under 1,0,0,1 backpressure.
    run_frame(1, WHITE, YELLOW, 1'b1, 1'b0);
    chk("bp_last_pixel", {23'd0, last_obs}, {23'd0, 3'd7, 3'd7, YELLOW});

    // Abort at pixel (3,5).
    @(posedge clk); #1;
    push_frame(0, WHITE, YELLOW, 30);
    done_before = done_total;
    mode    = 2'd0;
    color_a = WHITE;
    color_b = YELLOW;
    start   = 1'b1;
    found   = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (wr_en === 1'b1 && col == 3'd3 && row == 3'd5) begin
        abort_req = 1'b1;
        found     = 1;
      end
    end
    chk("abort_reached", found, 1);
    @(posedge clk); #1;
    abort_req = 1'b0;
    chk("abort_we_drop", {31'd0, wr_en}, 32'd0);
    chk("abort_busy_drop", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_total - done_before, 0);
    chk("abort_queue", exp_q.size(), 0);
    chk("abort_counters", {26'd0, col, row}, 32'd0);

    // Restart after abort begins again at (0,0).
    run_frame(0, WHITE, YELLOW, 1'b0, 1'b0);

    // Mid-fill start/colour/mode changes ignored; back-to-back next frame.
    run_frame(0, WHITE, YELLOW, 1'b0, 1'b1);
    run_frame(3, YELLOW, WHITE, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("total_done_pulses", done_total, 6);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pattern_fill_engine.md
# pattern_fill_engine

Hardware fill engine that writes a complete framebuffer pattern into the video RAM one pixel per cycle. It replaces software stripe/checker drawing loops (STO/VGA/INC/BLE sequences) with a parametrised scanner. It sits between the CPU, which issues start, mode and colours, and the video RAM write port. The CPU is free while the frame is filled.

## Interface
Parameters:
- COLS, 256, framebuffer width in pixels; power of two, ≥2
- ROWS, 256, framebuffer height in pixels; power of two, ≥2
- STRIPES, 4, stripes per axis; power of two, 2 ≤ STRIPES ≤ min(COLS, ROWS)
- COLOR_W, 3, pixel colour width (RGB, 3'b111 white, 3'b110 yellow)

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-low reset
- iStart  in  1  start request; sampled only in IDLE
- iAbort  in  1  stop fill; return to IDLE without oDone
- iMode  in  2  0 vertical stripes, 1 horizontal stripes, 2 checkerboard, 3 solid
- iColorA  in  COLOR_W  first colour
- iColorB  in  COLOR_W  second colour
- iWriteReady  in  1  RAM port accepts the current write
- oWriteEnable  out  1  write request valid
- oCol  out  clog2(COLS)  pixel column (x)
- oRow  out  clog2(ROWS)  pixel row (y)
- oColor  out  COLOR_W  pixel colour
- oBusy  out  1  high in RUN
- oDone  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, RUN, DONE.
- IDLE, iStart=1: latch iMode, iColorA and iColorB into internal registers. Clear the column and row counters. Go to RUN.
- RUN: oWriteEnable=1. oCol/oRow/oColor reflect the current pixel.
- A pixel is accepted when oWriteEnable && iWriteReady.
- On acceptance, the scan advances column-major: row increments first. At row=ROWS-1, row wraps to 0 and column increments.
- Acceptance of pixel (COLS-1, ROWS-1) moves the FSM to DONE.
- DONE: oDone=1 for exactly one cycle, then IDLE.
- iAbort=1 in RUN or DONE: go to IDLE next cycle. oWriteEnable drops, no oDone, counters clear. iAbort has priority over acceptance in the same cycle; that pixel's write still occurs on the bus.
- iStart is ignored in RUN/DONE. Changes to iMode and colour inputs during RUN have no effect.
- Colour rule, with cs = oCol >> log2(COLS/STRIPES) and rs = oRow >> log2(ROWS/STRIPES):
  - mode 0: cs[0]=0 → A, else B
  - mode 1: rs[0]=0 → A, else B
  - mode 2: (cs[0]^rs[0])=0 → A, else B
  - mode 3: A
- oColor is combinational from the registered counters and latched mode/colours. There is no arithmetic carry beyond counter wrap.
- Reset (Reset=0 at a rising edge, any state):
  - FSM → IDLE.
  - oWriteEnable, oBusy and oDone → 0.
  - oCol, oRow and latched colours → 0.
  - Latched mode → 0.
  - An in-flight fill is discarded.

## Timing
- Start latency: iStart high in cycle N → oWriteEnable=1 with pixel (0,0) in cycle N+1.
- Throughput: one pixel per cycle while iWriteReady=1. With iWriteReady held high, a fill spans COLS*ROWS RUN cycles.
- oDone is high in the cycle after the final acceptance. iStart is accepted again from the following cycle, the first IDLE cycle.
- Backpressure: while iWriteReady=0, oCol, oRow, oColor and oWriteEnable hold stable.
- oBusy = (state==RUN). oDone and oBusy are never high together.
- All state changes occur on the rising edge of Clock. No combinational path exists from iWriteReady to any output.

## Test plan
Bench parameters: COLS=8, ROWS=8, STRIPES=4, iWriteReady=1 unless noted.
- Reset: hold Reset=0 for 2 cycles during RUN → all outputs 0 the cycle after the first low edge. The FSM stays IDLE after Reset returns high.
- Mode 0, A=3'b111, B=3'b110, start → 64 writes in column-major order. Columns 0-1 and 4-5 get 3'b111, columns 2-3 and 6-7 get 3'b110. oDone pulses exactly once, cycle 66 after start.
- Mode 2, same colours → pixels (0,0)=111, (0,2)=110, (2,0)=110, (2,2)=111, (7,7)=111. Exactly 64 acceptances.
- Backpressure: toggle iWriteReady 1,0,0,1 repeatedly in mode 1 → no pixel skipped or duplicated. Outputs are stable during every stall. Final pixel is (7,7) with colour B.
- Abort: iAbort=1 at pixel (3,5) → oWriteEnable=0 next cycle, no oDone. A following iStart restarts at (0,0).
- Restart/ignore: pulse iStart and change iColorA mid-fill → no effect on the current frame. A new iStart the cycle after oDone begins a second full frame.
